// File: rtl/fft_serializer.sv
// Purpose: unpacks one captured 16-bin spectrum frame into a bin-0-first word stream.
// Latency: a frame captured at edge N presents bin 0 from cycle N+1; one bin per cycle at full rate.
// Backpressure: out_ready low holds state and outputs; frames arriving mid-stream are dropped and flagged.
module fft_serializer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fft_valid,
    input  logic [W-1:0] fft_d0,
    input  logic [W-1:0] fft_d1,
    input  logic [W-1:0] fft_d2,
    input  logic [W-1:0] fft_d3,
    input  logic [W-1:0] fft_d4,
    input  logic [W-1:0] fft_d5,
    input  logic [W-1:0] fft_d6,
    input  logic [W-1:0] fft_d7,
    input  logic [W-1:0] fft_d8,
    input  logic [W-1:0] fft_d9,
    input  logic [W-1:0] fft_d10,
    input  logic [W-1:0] fft_d11,
    input  logic [W-1:0] fft_d12,
    input  logic [W-1:0] fft_d13,
    input  logic [W-1:0] fft_d14,
    input  logic [W-1:0] fft_d15,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_d,
    output logic [3:0]   out_idx,
    output logic         out_sof,
    output logic         out_eof,
    output logic         busy,
    output logic         overflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   frame_q  [16];
    logic [W-1:0]   frame_in [16];

    logic           xfer;
    logic           last;
    logic           capture;
    logic           drop;

    // Gather the parallel bin ports into an indexable array.
    assign frame_in[0]  = fft_d0;
    assign frame_in[1]  = fft_d1;
    assign frame_in[2]  = fft_d2;
    assign frame_in[3]  = fft_d3;
    assign frame_in[4]  = fft_d4;
    assign frame_in[5]  = fft_d5;
    assign frame_in[6]  = fft_d6;
    assign frame_in[7]  = fft_d7;
    assign frame_in[8]  = fft_d8;
    assign frame_in[9]  = fft_d9;
    assign frame_in[10] = fft_d10;
    assign frame_in[11] = fft_d11;
    assign frame_in[12] = fft_d12;
    assign frame_in[13] = fft_d13;
    assign frame_in[14] = fft_d14;
    assign frame_in[15] = fft_d15;

    // Handshake events and next-state: a new frame is taken when idle or exactly on the final
    // transfer, giving zero-bubble back-to-back frames; any other arrival is a drop.
    always_comb begin
        xfer    = out_valid && out_ready;
        last    = xfer && (idx_q == 4'd15);
        capture = fft_valid && ((state_q == S_IDLE) || last);
        drop    = fft_valid && (state_q == S_SEND) && !last;

        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q | drop;

        if (capture) begin
            state_d = S_SEND;
            idx_d   = 4'd0;
        end else if (last) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
        end else if (xfer) begin
            idx_d   = idx_q + 4'd1;
        end
    end

    // Control registers: state, bin index and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Frame buffer: all 16 bins written together on capture, untouched by dropped frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                frame_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < 16; k++) begin
                frame_q[k] <= frame_in[k];
            end
        end
    end

    // Output decode from registered state only, so outputs are stable until the transfer.
    always_comb begin
        out_valid = (state_q == S_SEND);
        out_d     = out_valid ? frame_q[idx_q] : '0;
        out_idx   = out_valid ? idx_q : 4'd0;
        out_sof   = out_valid && (idx_q == 4'd0);
        out_eof   = out_valid && (idx_q == 4'd15);
        busy      = out_valid;
        overflow  = ovf_q;
    end

endmodule
